// File: rtl/serial_pkg.sv
// ============================================================================
// serial_pkg : shared types and helpers for the asynchronous serial TX
// Revision   : 1.0
// ============================================================================
`default_nettype none

package serial_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } t_tx_state;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Operand is zero-extended by the caller, which leaves the XOR reduction unchanged.
  function automatic logic calc_parity(input logic [31:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_async_tx_ext_sync_fifo.sv
// ============================================================================
// sync_fifo : single-clock FIFO with occupancy output (power-of-two depth)
// Revision  : 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [WIDTH-1:0]           i_data,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_level
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_lw = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wp;
  logic [c_aw-1:0]  r_rp;
  logic [c_lw-1:0]  r_level;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_level == c_lw'(DEPTH));
  assign o_empty = (r_level == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rp];
  assign o_level = r_level;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + c_aw'(1);
      if (w_pop)  r_rp <= r_rp + c_aw'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + c_lw'(1);
        2'b01:   r_level <= r_level - c_lw'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/serial_async_tx_ext.sv
// ============================================================================
// serial_async_tx_ext : UART-style transmitter, baud tick in the main clock
// domain, ready/valid input, gapless frames. Optional input FIFO via the
// SERIAL_TX_FIFO_EN macro.
// Revision            : 1.0
// ============================================================================
`default_nettype none

module serial_async_tx_ext
  import serial_pkg::*;
#(
  parameter int   MAIN_CLK_HZ          = 50_000_000,
  parameter int   SERIAL_CLK_HZ        = 9_600,
  parameter logic SERIAL_DATA_INACTIVE = 1'b1,
  parameter int   BITS                 = 8,
  parameter int   START_BITS           = 1,
  parameter int   PARITY_BITS          = 0,
  parameter logic PARITY_ODD           = 1'b0,
  parameter int   STOP_BITS            = 1,
  parameter logic LOWBIT_FIRST         = 1'b1,
  parameter int   FIFO_DEPTH           = 4
) (
  input  logic                            in_clk,
  input  logic                            in_rst,
  input  logic                            in_valid,
  output logic                            out_ready,
  input  logic [BITS-1:0]                 in_parallel,
  output logic                            out_serial,
  output logic                            out_busy,
  output logic                            out_word_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] out_fifo_level
);

  localparam int c_div    = MAIN_CLK_HZ / SERIAL_CLK_HZ;
  localparam int c_tick_w = (c_div > 1) ? $clog2(c_div) : 1;
  localparam int c_cnt_w  = $clog2(max4(BITS, START_BITS, PARITY_BITS, STOP_BITS)) + 1;

  generate
    if (c_div < 2) begin : g_div_chk
      $error("serial_async_tx_ext: MAIN_CLK_HZ / SERIAL_CLK_HZ must be at least 2");
    end
  endgenerate

  function automatic int phase_len(input t_tx_state s);
    case (s)
      ST_START:  return START_BITS;
      ST_DATA:   return BITS;
      ST_PARITY: return PARITY_BITS;
      ST_STOP:   return STOP_BITS;
      default:   return 0;
    endcase
  endfunction

  // ST_IDLE as a result means the frame has ended; the data phase is never empty.
  function automatic t_tx_state next_phase(input t_tx_state s);
    case (s)
      ST_IDLE:   return (START_BITS > 0) ? ST_START : ST_DATA;
      ST_START:  return ST_DATA;
      ST_DATA:   return (PARITY_BITS > 0) ? ST_PARITY : ((STOP_BITS > 0) ? ST_STOP : ST_IDLE);
      ST_PARITY: return (STOP_BITS > 0) ? ST_STOP : ST_IDLE;
      default:   return ST_IDLE;
    endcase
  endfunction

  function automatic logic line_level(input t_tx_state s, input logic [c_cnt_w-1:0] b,
                                      input logic [BITS-1:0] sh, input logic p);
    logic [BITS-1:0] t;
    t = LOWBIT_FIRST ? (sh >> b) : (sh << b);
    case (s)
      ST_START:  return 1'b0;
      ST_DATA:   return LOWBIT_FIRST ? t[0] : t[BITS-1];
      ST_PARITY: return p;
      ST_STOP:   return 1'b1;
      default:   return SERIAL_DATA_INACTIVE;
    endcase
  endfunction

  t_tx_state           r_state;
  logic [c_tick_w-1:0] r_tick;
  logic [c_cnt_w-1:0]  r_bit;
  logic [BITS-1:0]     r_shift;
  logic                r_par;
  logic                r_serial;

  t_tx_state           w_nxt_state;
  logic [c_tick_w-1:0] w_nxt_tick;
  logic [c_cnt_w-1:0]  w_nxt_bit;
  logic [BITS-1:0]     w_nxt_shift;
  logic                w_nxt_par;
  logic                w_tick_end;
  logic                w_bit_last;
  logic                w_frame_end;
  logic                w_load;
  logic [BITS-1:0]     w_load_data;

  assign w_tick_end  = (r_tick == c_tick_w'(c_div - 1));
  assign w_bit_last  = (r_bit == c_cnt_w'(phase_len(r_state) - 1));
  assign w_frame_end = (r_state != ST_IDLE) && w_tick_end && w_bit_last &&
                       (next_phase(r_state) == ST_IDLE);

`ifdef SERIAL_TX_FIFO_EN
  logic w_full;
  logic w_empty;

  assign out_ready = !in_rst && !w_full;
  assign w_load    = !w_empty && ((r_state == ST_IDLE) || w_frame_end);

  sync_fifo #(
    .WIDTH(BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (in_clk),
    .rst    (in_rst),
    .i_push (in_valid && out_ready),
    .i_pop  (w_load),
    .i_data (in_parallel),
    .o_data (w_load_data),
    .o_full (w_full),
    .o_empty(w_empty),
    .o_level(out_fifo_level)
  );
`else
  assign out_ready      = !in_rst && ((r_state == ST_IDLE) || w_frame_end);
  assign w_load         = in_valid && out_ready;
  assign w_load_data    = in_parallel;
  assign out_fifo_level = '0;
`endif

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_tick  = r_tick;
    w_nxt_bit   = r_bit;
    w_nxt_shift = r_shift;
    w_nxt_par   = r_par;
    if ((r_state == ST_IDLE) || w_frame_end) begin
      if (w_load) begin
        w_nxt_state = next_phase(ST_IDLE);
        w_nxt_tick  = '0;
        w_nxt_bit   = '0;
        w_nxt_shift = w_load_data;
        w_nxt_par   = calc_parity(32'(w_load_data), PARITY_ODD);
      end else if (w_frame_end) begin
        w_nxt_state = ST_IDLE;
        w_nxt_tick  = '0;
        w_nxt_bit   = '0;
      end
    end else if (w_tick_end) begin
      w_nxt_tick = '0;
      if (w_bit_last) begin
        w_nxt_state = next_phase(r_state);
        w_nxt_bit   = '0;
      end else begin
        w_nxt_bit = r_bit + c_cnt_w'(1);
      end
    end else begin
      w_nxt_tick = r_tick + c_tick_w'(1);
    end
  end

  // The line level is registered from the next-state values so it changes with the state.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      r_state  <= ST_IDLE;
      r_tick   <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_par    <= 1'b0;
      r_serial <= SERIAL_DATA_INACTIVE;
    end else begin
      r_state  <= w_nxt_state;
      r_tick   <= w_nxt_tick;
      r_bit    <= w_nxt_bit;
      r_shift  <= w_nxt_shift;
      r_par    <= w_nxt_par;
      r_serial <= line_level(w_nxt_state, w_nxt_bit, w_nxt_shift, w_nxt_par);
    end
  end

  assign out_serial    = r_serial;
  assign out_busy      = (r_state != ST_IDLE);
  assign out_word_done = w_frame_end;

endmodule

`default_nettype wire

// File: tb/tb_serial_async_tx_ext.sv
// ============================================================================
// tb_serial_async_tx_ext : directed bench for serial_async_tx_ext
// Revision               : 1.0
// ============================================================================
`default_nettype none

module tb_serial_async_tx_ext;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       vA, vBC;
  logic [7:0] dA, dBC;
  logic       readyA, serA, busyA, doneA;
  logic       readyB, serB, busyB, doneB;
  logic       readyC, serC, busyC, doneC;
  logic [2:0] lvlA, lvlB, lvlC;

  int n_tests = 0;
  int n_fail  = 0;

  // A: DIV=8, 8N1, LSB first
  serial_async_tx_ext #(
    .MAIN_CLK_HZ(8), .SERIAL_CLK_HZ(1), .BITS(8), .START_BITS(1),
    .PARITY_BITS(0), .STOP_BITS(1), .LOWBIT_FIRST(1'b1), .FIFO_DEPTH(4)
  ) u_a (
    .in_clk(clk), .in_rst(rst), .in_valid(vA), .out_ready(readyA),
    .in_parallel(dA), .out_serial(serA), .out_busy(busyA),
    .out_word_done(doneA), .out_fifo_level(lvlA)
  );

  // B: DIV=4, even parity, MSB first, two stop bits
  serial_async_tx_ext #(
    .MAIN_CLK_HZ(8), .SERIAL_CLK_HZ(2), .BITS(8), .START_BITS(1),
    .PARITY_BITS(1), .PARITY_ODD(1'b0), .STOP_BITS(2), .LOWBIT_FIRST(1'b0), .FIFO_DEPTH(4)
  ) u_b (
    .in_clk(clk), .in_rst(rst), .in_valid(vBC), .out_ready(readyB),
    .in_parallel(dBC), .out_serial(serB), .out_busy(busyB),
    .out_word_done(doneB), .out_fifo_level(lvlB)
  );

  // C: same as B with odd parity
  serial_async_tx_ext #(
    .MAIN_CLK_HZ(8), .SERIAL_CLK_HZ(2), .BITS(8), .START_BITS(1),
    .PARITY_BITS(1), .PARITY_ODD(1'b1), .STOP_BITS(2), .LOWBIT_FIRST(1'b0), .FIFO_DEPTH(4)
  ) u_c (
    .in_clk(clk), .in_rst(rst), .in_valid(vBC), .out_ready(readyC),
    .in_parallel(dBC), .out_serial(serC), .out_busy(busyC),
    .out_word_done(doneC), .out_fifo_level(lvlC)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered #1 after the accept edge; fv[i] is the i-th transmitted bit.
  task automatic frame_a(input logic [9:0] fv, input string nm);
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      chk({nm, " serial"}, 32'(serA), 32'(fv[(n-1)/8]));
      chk({nm, " busy"},   32'(busyA), 32'd1);
      chk({nm, " done"},   32'(doneA), (n == 80) ? 32'd1 : 32'd0);
      chk({nm, " ready"},  32'(readyA), (n == 80) ? 32'd1 : 32'd0);
    end
    @(posedge clk); #1;
  endtask

  task automatic frame_bc(input logic [7:0] w, input logic [11:0] eb, input logic [11:0] ec,
                          input string nm);
    @(negedge clk);
    vBC = 1'b1; dBC = w;
    chk({nm, " ready idle"}, 32'(readyB), 32'd1);
    @(posedge clk); #1;
    vBC = 1'b0;
    for (int n = 1; n <= 48; n++) begin
      @(negedge clk);
      chk({nm, " serial B"}, 32'(serB), 32'(eb[(n-1)/4]));
      chk({nm, " serial C"}, 32'(serC), 32'(ec[(n-1)/4]));
      chk({nm, " done B"},   32'(doneB), (n == 48) ? 32'd1 : 32'd0);
      chk({nm, " done C"},   32'(doneC), (n == 48) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    chk({nm, " idle serial B"}, 32'(serB), 32'd1);
    chk({nm, " idle busy C"},   32'(busyC), 32'd0);
  endtask

  initial begin
    rst = 1'b1; vA = 1'b0; vBC = 1'b0; dA = 8'h00; dBC = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst serial", 32'(serA), 32'd1);
    chk("rst busy",   32'(busyA), 32'd0);
    chk("rst readyA", 32'(readyA), 32'd0);
    chk("rst readyB", 32'(readyB), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post-rst readyA", 32'(readyA), 32'd1);
    chk("post-rst readyC", 32'(readyC), 32'd1);
    chk("post-rst done",   32'(doneA), 32'd0);
    chk("post-rst lvlA",   32'(lvlA), 32'd0);
    chk("post-rst lvlB",   32'(lvlB), 32'd0);
    chk("post-rst lvlC",   32'(lvlC), 32'd0);

    // Idle with in_valid low
    repeat (5) begin
      @(negedge clk);
      chk("idle serial", 32'(serA), 32'd1);
      chk("idle busy",   32'(busyA), 32'd0);
    end

    // Basic 8N1 frame, 0xA5 -> 0,1,0,1,0,0,1,0,1,1
    @(negedge clk);
    vA = 1'b1; dA = 8'hA5;
    @(posedge clk); #1;
    vA = 1'b0;
    frame_a(10'h34A, "a5");
    @(negedge clk);
    chk("a5 idle serial", 32'(serA), 32'd1);
    chk("a5 idle busy",   32'(busyA), 32'd0);

    // Parity and MSB-first with two stop bits
    frame_bc(8'h07, 12'hFC0, 12'hDC0, "p07");
    frame_bc(8'h80, 12'hE02, 12'hC02, "m80");

    // Back-to-back: in_parallel changes after the first accept and must not leak in
    @(negedge clk);
    vA = 1'b1; dA = 8'h11;
    @(posedge clk); #1;
    dA = 8'h22;
    frame_a(10'h222, "b2b1");
    vA = 1'b0;
    frame_a(10'h244, "b2b2");
    @(negedge clk);
    chk("b2b idle busy", 32'(busyA), 32'd0);

    // Reset during data bit 3 (clocks 33..40 after accept)
    @(negedge clk);
    vA = 1'b1; dA = 8'hFF;
    @(posedge clk); #1;
    vA = 1'b0;
    repeat (34) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("mid busy before rst", 32'(busyA), 32'd1);
    chk("ready held by rst",   32'(readyA), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid-rst serial", 32'(serA), 32'd1);
    chk("mid-rst busy",   32'(busyA), 32'd0);
    chk("mid-rst ready",  32'(readyA), 32'd1);
    chk("mid-rst done",   32'(doneA), 32'd0);
    chk("mid-rst level",  32'(lvlA), 32'd0);
    repeat (100) begin
      @(negedge clk);
      chk("dropped word silent", 32'(serA), 32'd1);
      chk("dropped word idle",   32'(busyA), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
